// File: rtl/peer_link_pkg.sv
// peer_link_pkg: shared types and default parameters for the peer link
// receive endpoint (peer_link_rx and its line filters).
package peer_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LINKED  = 2'd1,
        PLAYING = 2'd2,
        DONE    = 2'd3
    } link_state_t;

    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned FILTER_CYCLES_DEF = 1000;

endpackage

// File: rtl/peer_link_rx_if.sv
// peer_link_rx_if: the peer pin levels and local clear going in, the
// protocol events and link state coming out. The slave side is the
// receive endpoint; the master side drives the pins and reads the events.
interface peer_link_rx_if;
    import peer_link_pkg::*;

    logic        receive_connect;
    logic        receive_start;
    logic        receive_game_finish;
    logic        clear;

    logic        peer_connected;
    logic        peer_start;
    logic        peer_finish;
    logic        peer_lost;
    logic        proto_err;
    link_state_t link_state;

    modport master (
        output receive_connect, receive_start, receive_game_finish, clear,
        input  peer_connected, peer_start, peer_finish, peer_lost, proto_err,
               link_state
    );

    modport slave (
        input  receive_connect, receive_start, receive_game_finish, clear,
        output peer_connected, peer_start, peer_finish, peer_lost, proto_err,
               link_state
    );
endinterface

// File: rtl/peer_link_rx_line_filter.sv
// peer_line_filter: one asynchronous peer line -> synchroniser -> optional
// glitch filter -> rise/fall detector. rise/fall are decoded from registers
// and are valid for exactly one cycle.
// Build option: PEER_LINK_FILTER_EN enables the glitch filter; without it
// the filtered level is the synchroniser output and FILTER_CYCLES is unused.
module peer_line_filter
    import peer_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;

    // Synchroniser chain, bit 0 takes the raw asynchronous line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PEER_LINK_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Count consecutive cycles of disagreement; accept the new level once
    // the run reaches FILTER_CYCLES, any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_out != level_q) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    logic unused_filter_cfg;
    assign unused_filter_cfg = (FILTER_CYCLES == 0);
    assign level = sync_out;
`endif

    // Previous filtered level; clears in reset so a line already high at
    // release is reported as a fresh rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/peer_link_rx.sv
// peer_link_rx: receive-side endpoint of the two-board link. Filters the
// peer's connect/start/finish lines and tracks connect -> start -> finish,
// emitting single-cycle events for the local stage controller.
// Build option: PEER_LINK_FILTER_EN enables the per-line glitch filter.
module peer_link_rx
    import peer_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
    input logic           clk,
    input logic           rst,
    peer_link_rx_if.slave bus
);

    logic conn_rise, conn_fall, start_rise, fin_rise;
    logic unused_conn_level, unused_start_level, unused_start_fall;
    logic unused_fin_level, unused_fin_fall;

    link_state_t state_q;
    logic        conn_q, start_q, finish_q, lost_q, err_q;

    peer_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_connect (
        .clk    (clk),
        .rst    (rst),
        .line_i (bus.receive_connect),
        .level  (unused_conn_level),
        .rise   (conn_rise),
        .fall   (conn_fall)
    );

    peer_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_start (
        .clk    (clk),
        .rst    (rst),
        .line_i (bus.receive_start),
        .level  (unused_start_level),
        .rise   (start_rise),
        .fall   (unused_start_fall)
    );

    peer_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_finish (
        .clk    (clk),
        .rst    (rst),
        .line_i (bus.receive_game_finish),
        .level  (unused_fin_level),
        .rise   (fin_rise),
        .fall   (unused_fin_fall)
    );

    // Protocol FSM with registered outputs. Priority: connect fall, then
    // clear, then the rises. A start and finish rising together are both
    // judged against the current state, so one may advance while the other
    // is flagged as out of order in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            conn_q   <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;
            lost_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q  <= 1'b0;
            finish_q <= 1'b0;
            lost_q   <= 1'b0;
            err_q    <= 1'b0;
            if (conn_fall && state_q != IDLE) begin
                state_q <= IDLE;
                conn_q  <= 1'b0;
                lost_q  <= 1'b1;
            end else if (bus.clear && (state_q == PLAYING || state_q == DONE)) begin
                state_q <= LINKED;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (conn_rise) begin
                            state_q <= LINKED;
                            conn_q  <= 1'b1;
                        end
                        err_q <= start_rise | fin_rise;
                    end
                    LINKED: begin
                        if (start_rise) begin
                            state_q <= PLAYING;
                            start_q <= 1'b1;
                        end
                        err_q <= fin_rise;
                    end
                    PLAYING: begin
                        if (fin_rise) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                        end
                        err_q <= start_rise;
                    end
                    DONE: begin
                        err_q <= start_rise | fin_rise;
                    end
                    default: begin
                        state_q <= IDLE;
                        conn_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.link_state     = state_q;
    assign bus.peer_connected = conn_q;
    assign bus.peer_start     = start_q;
    assign bus.peer_finish    = finish_q;
    assign bus.peer_lost      = lost_q;
    assign bus.proto_err      = err_q;

endmodule

// File: tb/tb_peer_link_rx.sv
// tb_peer_link_rx: directed and randomized bench for peer_link_rx using
// SYNC_STAGES=2, FILTER_CYCLES=4. Expected outputs come from an event-level
// model of the link protocol.
module tb_peer_link_rx;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 4;
`ifdef PEER_LINK_FILTER_EN
    localparam int unsigned LAT = SYNC + FILT + 1;
`else
    localparam int unsigned LAT = SYNC + 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    peer_link_rx_if bus ();

    peer_link_rx #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: protocol state, accepted line levels, expected pulses.
    int m_state;
    bit m_conn, m_start, m_fin;
    bit e_start, e_fin, e_lost, e_err;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void clear_events();
        e_start = 1'b0;
        e_fin   = 1'b0;
        e_lost  = 1'b0;
        e_err   = 1'b0;
    endfunction

    // Applies one cycle's worth of accepted events to the protocol model.
    function automatic void model_event(bit cr, bit cf, bit sr, bit fr, bit clr);
        clear_events();
        if (cf && m_state != 0) begin
            m_state = 0;
            e_lost  = 1'b1;
        end else if (clr && m_state >= 2) begin
            m_state = 1;
        end else begin
            // start is legal only from LINKED, finish only from PLAYING
            e_err = (sr && m_state != 1) || (fr && m_state != 2);
            if (m_state == 0 && cr) begin
                m_state = 1;
            end else if (m_state == 1 && sr) begin
                m_state = 2;
                e_start = 1'b1;
            end else if (m_state == 2 && fr) begin
                m_state = 3;
                e_fin   = 1'b1;
            end
        end
    endfunction

    task automatic chk_outs(input string tag);
        logic [6:0] got, exp;
        got = {bus.link_state, bus.peer_connected, bus.peer_start,
               bus.peer_finish, bus.peer_lost, bus.proto_err};
        exp = {2'(m_state), (m_state != 0), e_start, e_fin, e_lost, e_err};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (state[2],conn,start,finish,lost,err)",
                   tag, got, exp);
        end
    endtask

    // Drive new raw levels, confirm nothing moves for LAT-1 edges, then the
    // event lands on edge LAT and its pulses last one cycle.
    task automatic drive_and_check(input bit c, input bit s, input bit f,
                                   input bit clr_with, input string tag);
        bit cr, cf, sr, fr;
        bus.receive_connect     = c;
        bus.receive_start       = s;
        bus.receive_game_finish = f;
        cr = c & ~m_conn;
        cf = ~c & m_conn;
        sr = s & ~m_start;
        fr = f & ~m_fin;
        m_conn  = c;
        m_start = s;
        m_fin   = f;
        for (int unsigned i = 1; i < LAT; i++) begin
            tick();
            chk_outs({tag, "_hold"});
        end
        if (clr_with) bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_event(cr, cf, sr, fr, clr_with);
        chk_outs({tag, "_evt"});
        clear_events();
        tick();
        chk_outs({tag, "_after"});
    endtask

    task automatic clear_pulse(input string tag);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_outs({tag, "_evt"});
        clear_events();
        tick();
        chk_outs({tag, "_after"});
    endtask

`ifdef PEER_LINK_FILTER_EN
    task automatic flip_line(input int unsigned line);
        case (line)
            0:       bus.receive_connect     = ~bus.receive_connect;
            1:       bus.receive_start       = ~bus.receive_start;
            default: bus.receive_game_finish = ~bus.receive_game_finish;
        endcase
    endtask

    // A level change shorter than the filter window must never surface.
    task automatic glitch(input int unsigned line, input int unsigned len,
                          input string tag);
        flip_line(line);
        for (int unsigned i = 0; i < len; i++) begin
            tick();
            chk_outs({tag, "_in"});
        end
        flip_line(line);
        for (int unsigned i = 0; i < LAT + 1; i++) begin
            tick();
            chk_outs({tag, "_out"});
        end
    endtask
`endif

    task automatic reset_and_release(input string tag);
        rst = 1'b0;
        tick();
        m_state = 0;
        m_conn  = 1'b0;
        m_start = 1'b0;
        m_fin   = 1'b0;
        clear_events();
        chk_outs({tag, "_rst"});
        tick();
        chk_outs({tag, "_rst2"});
        rst = 1'b1;
        drive_and_check(bus.receive_connect, bus.receive_start,
                        bus.receive_game_finish, 1'b0, {tag, "_rel"});
    endtask

    initial begin
        bit c, s, f, clr_with;
        int unsigned act;

        rst                     = 1'b0;
        bus.receive_connect     = 1'b0;
        bus.receive_start       = 1'b0;
        bus.receive_game_finish = 1'b0;
        bus.clear               = 1'b0;
        m_state = 0;
        m_conn  = 1'b0;
        m_start = 1'b0;
        m_fin   = 1'b0;
        clear_events();
        @(negedge clk);
        for (int unsigned i = 0; i < 3; i++) tick();
        chk_outs("reset");
        rst = 1'b1;
        tick();
        chk_outs("reset_release");

        drive_and_check(1, 0, 0, 0, "connect");
        drive_and_check(1, 1, 0, 0, "start");
`ifdef PEER_LINK_FILTER_EN
        glitch(2, FILT - 1, "fin_glitch");
        glitch(0, 1, "conn_glitch");
`endif
        drive_and_check(1, 1, 1, 0, "finish");
        clear_pulse("clear_done");
        drive_and_check(1, 0, 0, 0, "falls_ignored");
        drive_and_check(1, 0, 1, 0, "fin_in_linked");
        drive_and_check(1, 0, 0, 0, "fin_fall");
        drive_and_check(1, 1, 0, 0, "start2");
        drive_and_check(0, 1, 1, 0, "lost_with_fin");
        drive_and_check(1, 0, 0, 0, "reconnect");
        drive_and_check(1, 1, 1, 0, "start_fin_together");
        drive_and_check(1, 0, 0, 0, "drop_sf");
        drive_and_check(1, 0, 1, 1, "clear_beats_fin");
        drive_and_check(0, 0, 0, 0, "lost_linked");
        drive_and_check(0, 1, 0, 0, "start_in_idle");
        clear_pulse("clear_idle");
        drive_and_check(1, 0, 0, 0, "connect3");
        clear_pulse("clear_linked");
        drive_and_check(1, 1, 0, 0, "start3");
        reset_and_release("reset_mid_game");

        for (int unsigned n = 0; n < 80; n++) begin
            c = bus.receive_connect;
            s = bus.receive_start;
            f = bus.receive_game_finish;
            clr_with = ($urandom_range(0, 3) == 0);
            act = $urandom_range(0, 7);
            case (act)
                0, 1: c = ~c;
                2:    s = ~s;
                3:    f = ~f;
                4:    begin s = ~s; f = ~f; end
                5:    begin c = ~c; f = ~f; end
                default: ;
            endcase
            if (act == 6) begin
                clear_pulse("rnd_clear");
            end else if (act == 7) begin
`ifdef PEER_LINK_FILTER_EN
                glitch($urandom_range(0, 2), $urandom_range(1, FILT - 1), "rnd_glitch");
`else
                drive_and_check(c, ~s, f, clr_with, "rnd_start_only");
`endif
            end else begin
                drive_and_check(c, s, f, clr_with, "rnd_step");
            end
            if (n == 40) reset_and_release("rnd_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
